// File: rtl/wiegand_pkg.sv
// -----------------------------------------------------------------------------
// wiegand_pkg
// Shared definitions for the Wiegand transmitter: FSM state encoding and the
// default timing constants (in clk cycles) used as parameter defaults.
// -----------------------------------------------------------------------------
package wiegand_pkg;

  localparam int unsigned DEF_MAX_BITS   = 64;
  localparam int unsigned DEF_PULSE_CYC  = 28;
  localparam int unsigned DEF_PERIOD_CYC = 85;
  localparam int unsigned DEF_GAP_CYC    = 200;

  // Frame sequencing: one PULSE+SPACE pair per bit, GAP after the last bit.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    SPACE = 2'd2,
    GAP   = 2'd3
  } wiegand_state_e;

endpackage : wiegand_pkg

// File: rtl/wiegand_bit_timer.sv
// -----------------------------------------------------------------------------
// wiegand_bit_timer
// Per-bit phase counter. While enabled it counts 0..PERIOD_CYC-1 and wraps;
// it flags the last cycle of the low pulse and the last cycle of the period.
// Disabled, the counter is held at 0 so the first enabled cycle is phase 0.
//
// Ports
//   clk            : clock, rising edge
//   rst            : synchronous active-high reset
//   en_i           : count enable (a bit is being transmitted)
//   pulse_end_c_o  : combinational, last cycle of the low pulse
//   period_end_c_o : combinational, last cycle of the bit period
// -----------------------------------------------------------------------------
module wiegand_bit_timer
  import wiegand_pkg::*;
#(
  parameter int unsigned PULSE_CYC  = DEF_PULSE_CYC,
  parameter int unsigned PERIOD_CYC = DEF_PERIOD_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic pulse_end_c_o,
  output logic period_end_c_o
);

  localparam int unsigned CW = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;

  if (!(PULSE_CYC >= 1 && PULSE_CYC < PERIOD_CYC)) begin : g_bad_timing
    $error("wiegand_bit_timer: need 1 <= PULSE_CYC < PERIOD_CYC");
  end

  logic [CW-1:0] cnt_q, cnt_d;

  // Strobes
  always_comb begin
    pulse_end_c_o  = en_i && (cnt_q == CW'(PULSE_CYC - 1));
    period_end_c_o = en_i && (cnt_q == CW'(PERIOD_CYC - 1));
  end

  // Next phase: wrap at period end, park at 0 when disabled
  always_comb begin
    cnt_d = '0;
    if (en_i && !period_end_c_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : wiegand_bit_timer

// File: rtl/wiegand_tx.sv
// -----------------------------------------------------------------------------
// wiegand_tx
// Wiegand frame transmitter. A request (start while not busy) latches nbits
// and data; bits are then sent MSB-first (bit nbits-1 first) as low pulses on
// DATA0 (bit 0) or DATA1 (bit 1), followed by an idle gap, then done pulses.
// Requests with nbits = 0 or nbits > MAX_BITS are rejected with an err pulse.
//
// Build option: define WIEGAND_PARITY_EN to frame the payload with a leading
// even parity bit (upper ceil(n/2) bits) and a trailing odd parity bit
// (lower floor(n/2) bits), giving nbits+2 transmitted bits.
//
// Ports
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   start : frame request
//   nbits : payload bit count, $clog2(MAX_BITS+1) bits
//   data  : payload, MAX_BITS bits, bit nbits-1 sent first
//   d0    : DATA0 line, idle high, low pulse for a 0 bit (registered)
//   d1    : DATA1 line, idle high, low pulse for a 1 bit (registered)
//   busy  : frame or gap in progress (registered)
//   done  : one-cycle frame-complete pulse (registered)
//   err   : one-cycle rejected-request pulse (registered)
// -----------------------------------------------------------------------------
module wiegand_tx
  import wiegand_pkg::*;
#(
  parameter int unsigned MAX_BITS   = DEF_MAX_BITS,
  parameter int unsigned PULSE_CYC  = DEF_PULSE_CYC,
  parameter int unsigned PERIOD_CYC = DEF_PERIOD_CYC,
  parameter int unsigned GAP_CYC    = DEF_GAP_CYC
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [$clog2(MAX_BITS+1)-1:0] nbits,
  input  logic [MAX_BITS-1:0]           data,
  output logic                          d0,
  output logic                          d1,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);

  localparam int unsigned NBW = $clog2(MAX_BITS + 1);
`ifdef WIEGAND_PARITY_EN
  localparam int unsigned XB  = 2;
`else
  localparam int unsigned XB  = 0;
`endif
  localparam int unsigned FW  = MAX_BITS + XB;
  localparam int unsigned IW  = $clog2(FW + 1);
  localparam int unsigned GW  = $clog2(GAP_CYC + 1);

  if (GAP_CYC < 1) begin : g_bad_gap
    $error("wiegand_tx: need GAP_CYC >= 1");
  end

  wiegand_state_e  state_q, state_d;
  logic [FW-1:0]   sr_q, sr_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   last_q, last_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            d0_q, d0_d;
  logic            d1_q, d1_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic            tmr_en_c;
  logic            pulse_end_c;
  logic            period_end_c;
  logic            req_bad_c;
  logic [NBW-1:0]  pad_c;
  logic [MAX_BITS-1:0] payload_c;
  logic [FW-1:0]   frame_c;
  logic [FW-1:0]   sr_shift_c;

  wiegand_bit_timer #(
    .PULSE_CYC  (PULSE_CYC),
    .PERIOD_CYC (PERIOD_CYC)
  ) u_timer (
    .clk            (clk),
    .rst            (rst),
    .en_i           (tmr_en_c),
    .pulse_end_c_o  (pulse_end_c),
    .period_end_c_o (period_end_c)
  );

  // Timer runs only while bits are on the wire
  always_comb begin
    tmr_en_c = (state_q == PULSE) || (state_q == SPACE);
  end

  // Request validation and left-aligned payload (first bit at the MSB)
  always_comb begin
    req_bad_c = (nbits == '0) || (nbits > NBW'(MAX_BITS));
    pad_c     = NBW'(MAX_BITS) - nbits;
    payload_c = data << pad_c;
  end

`ifdef WIEGAND_PARITY_EN
  logic par_hi_c;
  logic par_lo_c;

  // Upper half is bits [n-1 : n/2], lower half is bits [n/2-1 : 0]
  always_comb begin
    par_hi_c = 1'b0;
    par_lo_c = 1'b0;
    for (int unsigned i = 0; i < MAX_BITS; i++) begin
      if (i < 32'(nbits)) begin
        if (i >= 32'(nbits >> 1)) begin
          par_hi_c = par_hi_c ^ data[i];
        end else begin
          par_lo_c = par_lo_c ^ data[i];
        end
      end
    end
  end

  // Even parity on top, payload, then odd parity just below the payload
  always_comb begin
    frame_c = {par_hi_c, payload_c, 1'b0} | (FW'(~par_lo_c) << pad_c);
  end
`else
  always_comb begin
    frame_c = payload_c;
  end
`endif

  always_comb begin
    sr_shift_c = sr_q << 1;
  end

  // Next-state and output logic
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    idx_d   = idx_q;
    last_d  = last_q;
    gap_d   = gap_q;
    d0_d    = d0_q;
    d1_d    = d1_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        d0_d   = 1'b1;
        d1_d   = 1'b1;
        busy_d = 1'b0;
        if (start) begin
          if (req_bad_c) begin
            err_d = 1'b1;
          end else begin
            state_d = PULSE;
            busy_d  = 1'b1;
            sr_d    = frame_c;
            idx_d   = '0;
            last_d  = IW'(nbits) + IW'(XB) - IW'(1);
            d0_d    = frame_c[FW-1];
            d1_d    = ~frame_c[FW-1];
          end
        end
      end

      PULSE: begin
        if (pulse_end_c) begin
          state_d = SPACE;
          d0_d    = 1'b1;
          d1_d    = 1'b1;
        end
      end

      SPACE: begin
        d0_d = 1'b1;
        d1_d = 1'b1;
        if (period_end_c) begin
          if (idx_q == last_q) begin
            state_d = GAP;
            gap_d   = '0;
          end else begin
            state_d = PULSE;
            idx_d   = idx_q + IW'(1);
            sr_d    = sr_shift_c;
            d0_d    = sr_shift_c[FW-1];
            d1_d    = ~sr_shift_c[FW-1];
          end
        end
      end

      GAP: begin
        d0_d = 1'b1;
        d1_d = 1'b1;
        if (gap_q == GW'(GAP_CYC - 1)) begin
          state_d = IDLE;
          gap_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end

      default: begin
        state_d = IDLE;
        d0_d    = 1'b1;
        d1_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      idx_q   <= '0;
      last_q  <= '0;
      gap_q   <= '0;
      d0_q    <= 1'b1;
      d1_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      gap_q   <= gap_d;
      d0_q    <= d0_d;
      d1_q    <= d1_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    d0   = d0_q;
    d1   = d1_q;
    busy = busy_q;
    done = done_q;
    err  = err_q;
  end

endmodule : wiegand_tx
